// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master; moves 36-bit parameter words as 40-bit frames {01,hi18,10,lo18}.
// Latency: FETCH(2) + SETUP/GAP + 40 bits of 2*CLK_DIV clk each + CHECK(1); HOLD ends the window.
// Optional build macro SPI_MASTER_RX_RAW_EN: skip RX marker checks, write every frame, frame_error stays 0.
module spi_master #(
  parameter int PARAM_WIDTH = 36,
  parameter int ADDR_WIDTH  = 8,
  parameter int CLK_DIV     = 8,
  parameter int SSEL_SETUP  = 8,
  parameter int FRAME_GAP   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  word_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  tx_rd_addr,
  input  logic [PARAM_WIDTH-1:0] tx_rd_data,
  output logic [ADDR_WIDTH-1:0]  rx_wr_addr,
  output logic [PARAM_WIDTH-1:0] rx_wr_data,
  output logic                   rx_wr_enable,
  output logic                   frame_error,
  output logic                   spi_SCLK,
  output logic                   spi_SSEL,
  output logic                   spi_MOSI,
  input  logic                   spi_MISO
);

  localparam int HW = PARAM_WIDTH / 2;
  localparam int FW = PARAM_WIDTH + 4;
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SSEL_SETUP - 1);
  // CHECK already contributes one low cycle after the final SCLK fall
  localparam logic [15:0] HOLD_LAST  = 16'(SSEL_SETUP - 2);
  localparam logic [15:0] GAP_LAST   = 16'(FRAME_GAP - 1);
  localparam logic [5:0]  BIT_LAST   = 6'(FW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_SHIFT, S_CHECK, S_GAP, S_HOLD
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         cnt;
  logic [5:0]          bit_cnt;
  logic                phase;      // 0: SCLK low half, 1: SCLK high half
  logic [FW-2:0]       tx_sr;      // bits still to go after the one on MOSI
  logic [FW-1:0]       rx_sr;
  logic [ADDR_WIDTH-1:0] words_q;
  logic                miso_q1, miso_s;
  logic                chk_d;
  logic                go, load, sample, fall, chk, fin;
  logic                last_frame, rx_ok;
  logic [FW-1:0]       framed;
  logic [PARAM_WIDTH-1:0] rx_payload;

  assign last_frame = (tx_rd_addr == words_q);
  assign framed     = {2'b01, tx_rd_data[PARAM_WIDTH-1:HW], 2'b10, tx_rd_data[HW-1:0]};
  assign rx_payload = {rx_sr[FW-3:HW+2], rx_sr[HW-1:0]};

`ifdef SPI_MASTER_RX_RAW_EN
  assign rx_ok = 1'b1;
`else
  assign rx_ok = (rx_sr[FW-1:FW-2] == 2'b01) && (rx_sr[HW+1:HW] == 2'b10);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go)                        state_nxt = S_FETCH;
      S_FETCH: if (load)                      state_nxt = spi_SSEL ? S_SETUP : S_SHIFT;
      S_SETUP: if (sample)                    state_nxt = S_SHIFT;
      S_SHIFT: if (fall && bit_cnt == BIT_LAST) state_nxt = S_CHECK;
      S_CHECK:                                state_nxt = last_frame ? S_HOLD : S_GAP;
      S_GAP:   if (cnt == GAP_LAST)           state_nxt = S_FETCH;
      S_HOLD:  if (fin)                       state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes; the last SETUP cycle doubles as bit 0's low phase
  always_comb begin
    go     = 1'b0;
    load   = 1'b0;
    sample = 1'b0;
    fall   = 1'b0;
    chk    = 1'b0;
    fin    = 1'b0;
    case (state)
      S_IDLE:  go     = start && !done;
      S_FETCH: load   = (cnt == 16'd1);
      S_SETUP: sample = (cnt == SETUP_LAST);
      S_SHIFT: begin
        sample = !phase && (cnt == DIV_LAST);
        fall   =  phase && (cnt == DIV_LAST);
      end
      S_CHECK: chk    = 1'b1;
      S_HOLD:  fin    = (cnt == HOLD_LAST);
      default: ;
    endcase
  end

  // Two-flop MISO synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_q1 <= 1'b0;
      miso_s  <= 1'b0;
    end else begin
      miso_q1 <= spi_MISO;
      miso_s  <= miso_q1;
    end
  end

  // Datapath: timers, shift registers, registered SPI pins and memory strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      phase        <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      words_q      <= '0;
      chk_d        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tx_rd_addr   <= '0;
      rx_wr_addr   <= '0;
      rx_wr_data   <= '0;
      rx_wr_enable <= 1'b0;
      frame_error  <= 1'b0;
      spi_SCLK     <= 1'b0;
      spi_SSEL     <= 1'b1;
      spi_MOSI     <= 1'b0;
    end else begin
      rx_wr_enable <= 1'b0;
      done         <= 1'b0;
      chk_d        <= chk;

      if (state == S_IDLE || state != state_nxt || (state == S_SHIFT && cnt == DIV_LAST))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;

      if (go) begin
        words_q     <= word_count;
        tx_rd_addr  <= '0;
        rx_wr_addr  <= '0;
        frame_error <= 1'b0;
        busy        <= 1'b1;
      end

      if (load) begin
        tx_sr    <= framed[FW-2:0];
        spi_MOSI <= framed[FW-1];
        phase    <= 1'b0;
        bit_cnt  <= '0;
        if (spi_SSEL) spi_SSEL <= 1'b0;
      end

      if (sample) begin
        rx_sr    <= {rx_sr[FW-2:0], miso_s};
        spi_SCLK <= 1'b1;
        phase    <= 1'b1;
      end

      if (fall) begin
        spi_SCLK <= 1'b0;
        phase    <= 1'b0;
        spi_MOSI <= tx_sr[FW-2];
        tx_sr    <= {tx_sr[FW-3:0], 1'b0};
        bit_cnt  <= bit_cnt + 6'd1;
      end

      if (chk) begin
        if (rx_ok) begin
          rx_wr_enable <= 1'b1;
          rx_wr_data   <= rx_payload;
        end else begin
          frame_error  <= 1'b1;
        end
        if (!last_frame) tx_rd_addr <= tx_rd_addr + 1'b1;
      end

      // Advance after the write cycle so RX index k always tracks frame k
      if (chk_d) rx_wr_addr <= rx_wr_addr + 1'b1;

      if (fin) begin
        spi_SSEL <= 1'b1;
        done     <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a mode-0 echo/zero responder.
// Memories and responder are behavioural; all pin observation happens on the falling clk edge.
// Each check is an immediate assertion that counts and reports failures.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  word_count = '0;
  logic        busy, done;
  logic [7:0]  tx_rd_addr, rx_wr_addr;
  logic [35:0] tx_rd_data, rx_wr_data;
  logic        rx_wr_enable, frame_error;
  logic        spi_SCLK, spi_SSEL, spi_MOSI;
  logic        spi_MISO = 1'b0;

  spi_master dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .busy(busy), .done(done), .tx_rd_addr(tx_rd_addr), .tx_rd_data(tx_rd_data),
    .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data), .rx_wr_enable(rx_wr_enable),
    .frame_error(frame_error), .spi_SCLK(spi_SCLK), .spi_SSEL(spi_SSEL),
    .spi_MOSI(spi_MOSI), .spi_MISO(spi_MISO)
  );

  always #5 clk = ~clk;

  localparam logic [39:0] ECHO0 = 40'h4000080000;  // valid frame, zero payload

  logic [35:0] tx_mem [256];
  logic [35:0] rx_mem [256];

  // TX memory with one-cycle read latency
  always @(posedge clk) tx_rd_data <= tx_mem[tx_rd_addr];

  int tests = 0;
  int fails = 0;
  logic zero_mode = 1'b0;
  logic clr_req = 1'b0;
  logic timed_out;

  int n_rise, n_ssel_fall, n_wr, n_done, run_len;
  int hi_q[$], lo_q[$], tail_q[$];
  logic [39:0] mosi_q[$];
  logic prev_ssel = 1'b1, prev_sclk = 1'b0;
  logic [39:0] in_sr, out_sr, nxt_fr;
  int r_cnt;
  logic r_pend;

  // Pin monitor, SPI responder and RX memory
  always @(negedge clk) begin
    if (clr_req) begin
      n_rise = 0; n_ssel_fall = 0; n_wr = 0; n_done = 0;
      hi_q.delete(); lo_q.delete(); tail_q.delete(); mosi_q.delete();
    end
    if (!spi_SSEL && prev_ssel) begin
      run_len = 1; n_ssel_fall++;
    end else if (!spi_SSEL) begin
      if (spi_SCLK !== prev_sclk) begin
        if (prev_sclk) hi_q.push_back(run_len);
        else           lo_q.push_back(run_len);
        run_len = 1;
      end else run_len++;
    end else if (!prev_ssel) tail_q.push_back(run_len);

    if (spi_SSEL) begin
      r_cnt = 0; r_pend = 1'b0; out_sr = ECHO0;
    end else if (spi_SCLK && !prev_sclk) begin
      n_rise++;
      in_sr = {in_sr[38:0], spi_MOSI};
      r_cnt++;
      if (r_cnt == 40) begin
        mosi_q.push_back(in_sr); nxt_fr = in_sr; r_cnt = 0; r_pend = 1'b1;
      end
    end else if (!spi_SCLK && prev_sclk) begin
      if (r_pend) begin out_sr = nxt_fr; r_pend = 1'b0; end
      else out_sr = {out_sr[38:0], 1'b0};
    end
    spi_MISO = zero_mode ? 1'b0 : out_sr[39];

    if (rx_wr_enable) begin rx_mem[rx_wr_addr] = rx_wr_data; n_wr++; end
    if (done) n_done++;
    prev_ssel = spi_SSEL;
    prev_sclk = spi_SCLK;
  end

  function automatic logic [39:0] frm(input logic [35:0] d);
    return {2'b01, d[35:18], 2'b10, d[17:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    clr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic kick(input logic [7:0] wc);
    word_count = wc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    timed_out = !seen;
  endtask

  task automatic run(input string tag, input logic [7:0] wc);
    clr();
    kick(wc);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done();
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  int mn, mx, wr_before;
  logic hit;

  initial begin
    for (int i = 0; i < 256; i++) begin tx_mem[i] = '0; rx_mem[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ssel", 64'(spi_SSEL), 64'd1);
    chk("rst_sclk", 64'(spi_SCLK), 64'd0);
    chk("rst_mosi", 64'(spi_MOSI), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wren", 64'(rx_wr_enable), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);
    chk("rst_addrs", {tx_rd_addr, rx_wr_addr, 28'd0, rx_wr_data}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single word framing and SCLK timing
    tx_mem[0] = 36'h123456789;
    run("single", 8'd0);
    chk("single_nframes", 64'(mosi_q.size()), 64'd1);
    chk("single_mosi", 64'(mosi_q[0]), 64'h448D196789);
    chk("single_rises", 64'(n_rise), 64'd40);
    chk("single_ssel_falls", 64'(n_ssel_fall), 64'd1);
    chk("single_done", 64'(n_done), 64'd1);
    chk("single_ssel_to_rise", 64'(lo_q[0]), 64'd8);
    mn = 1000; mx = 0;
    foreach (hi_q[i]) begin if (hi_q[i] < mn) mn = hi_q[i]; if (hi_q[i] > mx) mx = hi_q[i]; end
    chk("sclk_high_min", 64'(mn), 64'd8);
    chk("sclk_high_max", 64'(mx), 64'd8);
    mn = 1000; mx = 0;
    foreach (lo_q[i]) begin if (lo_q[i] < mn) mn = lo_q[i]; if (lo_q[i] > mx) mx = lo_q[i]; end
    chk("sclk_low_min", 64'(mn), 64'd8);
    chk("sclk_low_max", 64'(mx), 64'd8);
    chk("fall_to_ssel_rise", 64'(tail_q[0]), 64'd8);
    chk("single_wr", 64'(n_wr), 64'd1);

    // Four-word loopback
    for (int i = 0; i < 4; i++) tx_mem[i] = 36'(i + 1);
    run("loop", 8'd3);
    chk("loop_rx1", 64'(rx_mem[1]), 64'd1);
    chk("loop_rx2", 64'(rx_mem[2]), 64'd2);
    chk("loop_rx3", 64'(rx_mem[3]), 64'd3);
    chk("loop_wr", 64'(n_wr), 64'd4);
    chk("loop_ferr", 64'(frame_error), 64'd0);
    chk("loop_rxaddr", 64'(rx_wr_addr), 64'd4);
    chk("loop_gap1", 64'(lo_q[40]), 64'd19);
    chk("loop_gap2", 64'(lo_q[80]), 64'd19);
    chk("loop_mosi3", 64'(mosi_q[3]), 64'(frm(36'd4)));

    // Responder holds MISO low: framing errors, no writes
    zero_mode = 1'b1;
    run("zero", 8'd1);
    chk("zero_ferr", 64'(frame_error), 64'd1);
    chk("zero_wr", 64'(n_wr), 64'd0);
    chk("zero_rxaddr", 64'(rx_wr_addr), 64'd2);
    chk("zero_done", 64'(n_done), 64'd1);
    zero_mode = 1'b0;

    // Reset in the middle of frame 1 of 3
    tx_mem[0] = 36'hA5A5A5A5A; tx_mem[1] = 36'h0F0F0F0F0; tx_mem[2] = 36'hFFFFFFFFF;
    clr();
    kick(8'd2);
    hit = 1'b0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      if (n_rise >= 61) hit = 1'b1;
    end
    chk("midrst_reach", 64'(hit), 64'd1);
    wr_before = n_wr;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ssel", 64'(spi_SSEL), 64'd1);
    chk("midrst_sclk", 64'(spi_SCLK), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wren", 64'(rx_wr_enable), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_nowrite", 64'(n_wr), 64'(wr_before));
    run("rerun", 8'd2);
    chk("rerun_nframes", 64'(mosi_q.size()), 64'd3);
    chk("rerun_mosi0", 64'(mosi_q[0]), 64'(frm(36'hA5A5A5A5A)));
    chk("rerun_mosi2", 64'(mosi_q[2]), 64'(frm(36'hFFFFFFFFF)));
    chk("rerun_rx1", 64'(rx_mem[1]), 64'h0A5A5A5A5A);
    chk("rerun_rx2", 64'(rx_mem[2]), 64'h00F0F0F0F0);
    chk("rerun_wr", 64'(n_wr), 64'd3);
    chk("rerun_ferr_cleared", 64'(frame_error), 64'd0);

    // Start while busy, word_count change, and start in the done cycle
    clr();
    kick(8'd1);
    repeat (100) @(negedge clk);
    word_count = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ign_timeout", 64'(timed_out), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("ign_rises", 64'(n_rise), 64'd80);
    chk("ign_nframes", 64'(mosi_q.size()), 64'd2);
    chk("ign_ssel_falls", 64'(n_ssel_fall), 64'd1);
    chk("ign_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
